uart_sink: RTL and testbench

UART_SINK -- requirements
Module: uart_sink

---
 rtl/uart_sink.sv | 160 ++++++++++++++++
 tb/tb_uart_sink.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_sink.sv
// rtl/uart_sink.sv - 8N1 serial receiver that assembles BYTES-byte messages
//
// Ports:
//   iCLOCK   in   1          clock, rising edge
//   iNRESET  in   1          synchronous active-low reset
//   iRX      in   1          serial line, idles high, asynchronous to iCLOCK
//   oRECEPT  out  1          high while a message is being received
//   oDONE    out  1          one-cycle pulse when a full message has arrived
//   oFDATA   out  BYTES*8    last complete message, first byte in [7:0]
module uart_sink #(
    parameter int SCYCLE   = 50000000,
    parameter int BAUDRATE = 115200,
    parameter int BYTES    = 8
) (
    input  logic               iCLOCK,
    input  logic               iNRESET,
    input  logic               iRX,
    output logic               oRECEPT,
    output logic               oDONE,
    output logic [BYTES*8-1:0] oFDATA
);
    localparam int DIV = SCYCLE / BAUDRATE;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(BYTES + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_rx_prev;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic [BW-1:0]      r_byte_cnt;
    logic [BYTES*8-1:0] r_asm;
    logic [BYTES*8-1:0] r_fdata;
    logic               r_recept;
    logic               r_done;

    logic               w_rx_s;
    logic               w_fall;
    logic               w_mid;
    logic               w_tick;
    logic               w_bit_tick;
    logic               w_stop_tick;
    logic               w_last;
    logic [BYTES*8-1:0] w_asm_next;

    assign w_rx_s      = r_sync2;
    // Edge detect uses the previous synchronized sample, so after a framing
    // error with the line still low the block re-arms only once it goes high.
    assign w_fall      = (r_state == S_IDLE) && r_rx_prev && !w_rx_s;
    assign w_mid       = (r_state == S_START) && (r_cnt == CW'(DIV / 2 - 1));
    assign w_tick      = (r_cnt == CW'(DIV - 1));
    assign w_bit_tick  = (r_state == S_DATA) && w_tick;
    assign w_stop_tick = (r_state == S_STOP) && w_tick;
    assign w_last      = (r_byte_cnt == BW'(BYTES - 1));

    // Assembly register with the finished byte dropped into lane r_byte_cnt.
    always_comb begin
        w_asm_next = r_asm;
        for (int k = 0; k < BYTES; k++) begin
            if (r_byte_cnt == BW'(k)) begin
                w_asm_next[8*k +: 8] = r_shift;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fall) w_next = S_START;
            S_START: if (w_mid) w_next = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_bit_tick && (r_bit == 3'd7)) w_next = S_STOP;
            S_STOP:  if (w_stop_tick) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (!iNRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (!iNRESET) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
            r_fdata    <= '0;
            r_recept   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_sync1   <= iRX;
            r_sync2   <= r_sync1;
            r_rx_prev <= w_rx_s;
            r_done    <= 1'b0;

            // Counter restarts at every sampling point so data samples land
            // DIV clocks apart, starting from the start-bit mid-point.
            if ((r_state == S_IDLE) || w_mid || w_bit_tick || w_stop_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_fall) begin
                r_recept <= 1'b1;
            end

            if (w_mid) begin
                r_bit <= '0;
                // A rejected glitch only ends reception if no byte is pending.
                if (w_rx_s && (r_byte_cnt == '0)) begin
                    r_recept <= 1'b0;
                end
            end

            if (w_bit_tick) begin
                r_shift[r_bit] <= w_rx_s;
                if (r_bit != 3'd7) begin
                    r_bit <= r_bit + 3'd1;
                end
            end

            if (w_stop_tick) begin
                if (w_rx_s) begin
                    r_asm <= w_asm_next;
                    if (w_last) begin
                        r_fdata    <= w_asm_next;
                        r_done     <= 1'b1;
                        r_recept   <= 1'b0;
                        r_byte_cnt <= '0;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + BW'(1);
                    end
                end else begin
                    r_byte_cnt <= '0;
                    r_recept   <= 1'b0;
                end
            end
        end
    end

    // Outputs read as zero for the whole time reset is held low.
    assign oRECEPT = iNRESET & r_recept;
    assign oDONE   = iNRESET & r_done;
    assign oFDATA  = iNRESET ? r_fdata : '0;

endmodule

// File: tb/tb_uart_sink.sv
// tb/tb_uart_sink.sv - randomized self-checking bench for uart_sink
module tb_uart_sink;
    localparam int SCYCLE = 50000000;
    localparam int BAUD   = 2000000;
    localparam int DIV    = SCYCLE / BAUD;
    localparam int NB     = 8;

    logic            iCLOCK = 1'b0;
    logic            iNRESET = 1'b0;
    logic            iRX = 1'b1;
    logic            oRECEPT;
    logic            oDONE;
    logic [NB*8-1:0] oFDATA;

    int              n_tests = 0;
    int              n_fail = 0;
    int              done_cnt = 0;
    int              dbl_cnt = 0;
    logic            prev_done = 1'b0;

    int              exp_done = 0;
    logic [63:0]     exp_fdata = '0;
    logic [7:0]      model_q[$];

    uart_sink #(.SCYCLE(SCYCLE), .BAUDRATE(BAUD), .BYTES(NB)) dut (
        .iCLOCK (iCLOCK),
        .iNRESET(iNRESET),
        .iRX    (iRX),
        .oRECEPT(oRECEPT),
        .oDONE  (oDONE),
        .oFDATA (oFDATA)
    );

    always #10 iCLOCK = ~iCLOCK;

    always @(negedge iCLOCK) begin
        if (oDONE) begin
            done_cnt++;
            if (prev_done) dbl_cnt++;
        end
        prev_done = oDONE;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        model_q.push_back(b);
        if (model_q.size() == NB) begin
            for (int i = 0; i < NB; i++) exp_fdata[8*i +: 8] = model_q[i];
            exp_done++;
            model_q.delete();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        logic [9:0] frame;
        frame = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            iRX = frame[i];
            repeat (DIV) @(negedge iCLOCK);
            if (i == 4) check("recept_in_byte", 64'(oRECEPT), 64'(1));
        end
        if (!stop_ok) begin
            iRX = 1'b1;
            repeat (DIV) @(negedge iCLOCK);
            model_q.delete();
        end else begin
            model_push(b);
        end
        check("recept_after_byte", 64'(oRECEPT), 64'(model_q.size() > 0));
        check("done_count", 64'(done_cnt), 64'(exp_done));
    endtask

    task automatic send_msg(input logic [63:0] msg);
        logic [63:0] m;
        m = msg;
        for (int i = 0; i < NB; i++) send_byte(m[8*i +: 8], 1'b1);
        check("msg_fdata", oFDATA, exp_fdata);
    endtask

    task automatic glitch(input int len);
        iRX = 1'b0;
        repeat (len) @(negedge iCLOCK);
        iRX = 1'b1;
        repeat (2 * DIV) @(negedge iCLOCK);
        check("glitch_recept", 64'(oRECEPT), 64'(model_q.size() > 0));
        check("glitch_done", 64'(done_cnt), 64'(exp_done));
        check("glitch_fdata", oFDATA, exp_fdata);
    endtask

    initial begin
        int idle_bad;
        logic [7:0] rb;
        logic [7:0] pb;
        logic [63:0] msg_a;
        logic [63:0] msg_b;
        msg_a = 64'hB1B0AFAEADACABAA;
        msg_b = 64'hB1B0AFAEADACABAB;

        repeat (3) @(negedge iCLOCK);
        check("rst_recept", 64'(oRECEPT), 64'(0));
        check("rst_done", 64'(oDONE), 64'(0));
        check("rst_fdata", oFDATA, 64'(0));
        iNRESET = 1'b1;
        repeat (DIV) @(negedge iCLOCK);

        send_msg(msg_a);
        check("msg_a_fdata", oFDATA, 64'hB1B0AFAEADACABAA);
        send_msg(msg_b);
        check("msg_b_fdata", oFDATA, 64'hB1B0AFAEADACABAB);

        glitch(DIV / 4);

        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        glitch(DIV / 4);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b0);
        send_msg(msg_a);
        check("frame_fdata", oFDATA, 64'hB1B0AFAEADACABAA);

        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        pb = 8'h5A;
        iRX = 1'b0;
        repeat (DIV) @(negedge iCLOCK);
        for (int i = 0; i < 4; i++) begin
            iRX = pb[i];
            repeat (DIV) @(negedge iCLOCK);
        end
        iRX = pb[4];
        repeat (DIV / 2) @(negedge iCLOCK);
        iNRESET = 1'b0;
        #1;
        check("mid_rst_recept", 64'(oRECEPT), 64'(0));
        check("mid_rst_done", 64'(oDONE), 64'(0));
        check("mid_rst_fdata", oFDATA, 64'(0));
        @(negedge iCLOCK);
        iNRESET = 1'b1;
        iRX = 1'b1;
        model_q.delete();
        exp_fdata = '0;
        repeat (2 * DIV) @(negedge iCLOCK);
        check("post_rst_recept", 64'(oRECEPT), 64'(0));
        check("post_rst_fdata", oFDATA, 64'(0));
        send_msg(msg_b);

        idle_bad = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge iCLOCK);
            if (oRECEPT || oDONE) idle_bad++;
        end
        check("idle_quiet", 64'(idle_bad), 64'(0));

        for (int m = 0; m < 3; m++) begin
            int target;
            target = exp_done + 1;
            for (int n = 0; n < 24 && exp_done < target; n++) begin
                rb = 8'($urandom);
                send_byte(rb, ($urandom_range(0, 9) != 0));
                iRX = 1'b1;
                repeat ($urandom_range(0, 2 * DIV)) @(negedge iCLOCK);
            end
            check("rand_done", 64'(done_cnt), 64'(exp_done));
            check("rand_fdata", oFDATA, exp_fdata);
        end

        check("done_width", 64'(dbl_cnt), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
